// File: rtl/gene_net_pkg.sv
// Shared types and update rule for the 8-gene Boolean network (forward and preimage blocks).
package gene_net_pkg;
  localparam int N_GENES = 8;
  typedef logic [N_GENES-1:0] gstate_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic gstate_t gene_step(input gstate_t x);
    gstate_t o;
    o[0] = ~x[2] & x[6] & ~x[7];
    o[1] = (x[4] | x[5]) & ~x[7];
    o[2] = x[7];
    o[3] = x[1] & ~x[6];
    o[4] = x[1] | x[3];
    o[5] = x[2] & ~x[7];
    o[6] = x[1] & ~x[7];
    o[7] = ~(x[0] | x[1]) & (x[3] | x[6]);
    return o;
  endfunction
endpackage

// File: rtl/gene_net_step.sv
// Combinational x -> f(x) wrapper, shared by the forward network and the preimage scanner.
module gene_net_step
  import gene_net_pkg::*;
(
  input  logic [N_GENES-1:0] x,
  output logic [N_GENES-1:0] o
);
  assign o = gene_step(x);
endmodule

// File: rtl/gene_net_preimage.sv
// Preimage scanner: streams every x with f(x)==target in ascending order, then reports the count.
// Optional m_fixed output (x==target) when GENE_PRE_FIXEDPT_EN is defined.
module gene_net_preimage
  import gene_net_pkg::*;
#(
  parameter bit FIRST_ONLY = 1'b0,
  parameter int N_GENES    = gene_net_pkg::N_GENES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_GENES-1:0] target,
  output logic               busy,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [N_GENES-1:0] m_state,
`ifdef GENE_PRE_FIXEDPT_EN
  output logic               m_fixed,
`endif
  output logic               done,
  output logic [N_GENES:0]   count
);
  logic [1:0]         state_q, state_d;
  logic [N_GENES:0]   cand_q, cand_d, cand_inc;
  logic [N_GENES-1:0] target_q, target_d;
  logic [N_GENES-1:0] out_state_q, out_state_d;
  logic               out_vld_q, out_vld_d;
  logic [N_GENES:0]   count_q, count_d;
  logic [N_GENES-1:0] cand_img;
  logic               match, slot_free, load;
`ifdef GENE_PRE_FIXEDPT_EN
  logic               out_fixed_q, out_fixed_d;
`endif

  gene_net_step u_step (.x(cand_q[N_GENES-1:0]), .o(cand_img));

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    target_d    = target_q;
    out_state_d = out_state_q;
    out_vld_d   = out_vld_q;
    count_d     = count_q;
`ifdef GENE_PRE_FIXEDPT_EN
    out_fixed_d = out_fixed_q;
`endif
    cand_inc  = cand_q + 1'b1;
    match     = (state_q == SCAN) && (cand_img == target_q);
    slot_free = ~out_vld_q | m_ready;
    load      = match & slot_free;

    if (out_vld_q && m_ready) out_vld_d = 1'b0;
    if (load) begin
      out_vld_d   = 1'b1;
      out_state_d = cand_q[N_GENES-1:0];
      count_d     = count_q + 1'b1;
`ifdef GENE_PRE_FIXEDPT_EN
      out_fixed_d = (cand_q[N_GENES-1:0] == target_q);
`endif
    end

    case (state_q)
      IDLE: if (start) begin
        state_d  = SCAN;
        target_d = target;
        cand_d   = '0;
        count_d  = '0;
      end
      // A match with a full, unaccepted slot holds the candidate so nothing is dropped.
      SCAN: if (!match || slot_free) begin
        cand_d = cand_inc;
        if (cand_inc[N_GENES] || (FIRST_ONLY && load)) state_d = DRAIN;
      end
      DRAIN: if (slot_free) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      target_q    <= '0;
      out_state_q <= '0;
      out_vld_q   <= 1'b0;
      count_q     <= '0;
`ifdef GENE_PRE_FIXEDPT_EN
      out_fixed_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      target_q    <= target_d;
      out_state_q <= out_state_d;
      out_vld_q   <= out_vld_d;
      count_q     <= count_d;
`ifdef GENE_PRE_FIXEDPT_EN
      out_fixed_q <= out_fixed_d;
`endif
    end
  end

  assign busy    = (state_q == SCAN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign m_valid = out_vld_q;
  assign m_state = out_state_q;
  assign count   = count_q;
`ifdef GENE_PRE_FIXEDPT_EN
  assign m_fixed = out_fixed_q;
`endif
endmodule

// File: tb/tb_gene_net_preimage.sv
// Directed bench for gene_net_preimage: default instance plus a FIRST_ONLY=1 instance.
module tb_gene_net_preimage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start_f = 1'b0;
  logic [7:0] target = 8'h00;
  logic       m_ready = 1'b1;
  logic       busy, m_valid, done;
  logic [7:0] m_state;
  logic [8:0] count;
  logic       busy_f, m_valid_f, done_f;
  logic [7:0] m_state_f;
  logic [8:0] count_f;
`ifdef GENE_PRE_FIXEDPT_EN
  logic       m_fixed, m_fixed_f;
  logic       fx[$];
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] got[$];
  logic [7:0] ref4[$];

  always #5 clk = ~clk;

  gene_net_preimage #(.FIRST_ONLY(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .busy(busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_state(m_state),
`ifdef GENE_PRE_FIXEDPT_EN
    .m_fixed(m_fixed),
`endif
    .done(done), .count(count));

  gene_net_preimage #(.FIRST_ONLY(1'b1)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .target(target), .busy(busy_f),
    .m_valid(m_valid_f), .m_ready(m_ready), .m_state(m_state_f),
`ifdef GENE_PRE_FIXEDPT_EN
    .m_fixed(m_fixed_f),
`endif
    .done(done_f), .count(count_f));

  function automatic logic [7:0] f_ref(input logic [7:0] x);
    logic [7:0] o;
    o[0] = ~x[2] & x[6] & ~x[7];
    o[1] = (x[4] | x[5]) & ~x[7];
    o[2] = x[7];
    o[3] = x[1] & ~x[6];
    o[4] = x[1] | x[3];
    o[5] = x[2] & ~x[7];
    o[6] = x[1] & ~x[7];
    o[7] = ~(x[0] | x[1]) & (x[3] | x[6]);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One scan on dut; collects accepted beats and stall stability, bounded by a cycle budget.
  task automatic run_scan(input logic [7:0] t, input bit rnd_ready, input bit poke,
                          output int done_cyc, output int cnt, output int stall_bad,
                          output int stalls, output int nvalid, output logic busy1);
    int cyc;
    bit pend;
    logic [7:0] pend_state;
    got.delete();
`ifdef GENE_PRE_FIXEDPT_EN
    fx.delete();
`endif
    done_cyc = -1; cnt = -1; stall_bad = 0; stalls = 0; nvalid = 0; pend = 0;
    pend_state = 8'h00;
    target = t; m_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    cyc = 1;
    while (done_cyc < 0 && cyc < 2000) begin
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      if (poke && cyc == 20) begin start = 1'b1; target = 8'hFF; end
      else start = 1'b0;
      @(negedge clk);
      if (pend && !(m_valid && m_state == pend_state)) stall_bad++;
      if (m_valid) nvalid++;
      if (m_valid && m_ready) begin
        got.push_back(m_state);
`ifdef GENE_PRE_FIXEDPT_EN
        fx.push_back(m_fixed);
`endif
      end
      pend = m_valid && !m_ready;
      pend_state = m_state;
      if (pend) stalls++;
      if (done) begin done_cyc = cyc; cnt = int'(count); end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    int dc, cn, sb, st, nv, bad_asc, bad_f, diff, beats, cyc;
    logic b1;
    logic [7:0] first;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_m_state", m_state, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T=0x00: predecessors 0x00, 0x01; target change mid-scan ignored
    run_scan(8'h00, 1'b0, 1'b1, dc, cn, sb, st, nv, b1);
    chk("t00_busy_after_start", b1, 1);
    chk("t00_beats", got.size(), 2);
    if (got.size() == 2) begin
      chk("t00_beat0", got[0], 8'h00);
      chk("t00_beat1", got[1], 8'h01);
`ifdef GENE_PRE_FIXEDPT_EN
      chk("t00_fixed0", fx[0], 1);
      chk("t00_fixed1", fx[1], 0);
`endif
    end
    chk("t00_done_cycle", dc, 258);
    chk("t00_count", cn, 2);
    chk("t00_busy_idle", busy, 0);
    chk("t00_count_hold", count, 2);

    // T=0x04, always ready: 24 ascending predecessors 0x80..0xF5
    run_scan(8'h04, 1'b0, 1'b0, dc, cn, sb, st, nv, b1);
    chk("t04_beats", got.size(), 24);
    if (got.size() == 24) begin
      chk("t04_first", got[0], 8'h80);
      chk("t04_last", got[23], 8'hF5);
    end
    bad_asc = 0; bad_f = 0;
    foreach (got[i]) begin
      if (i > 0 && got[i] <= got[i-1]) bad_asc++;
      if (f_ref(got[i]) != 8'h04) bad_f++;
    end
    chk("t04_ascending", bad_asc, 0);
    chk("t04_f_equals_t", bad_f, 0);
    chk("t04_count", cn, 24);
    chk("t04_done_cycle", dc, 258);
    ref4 = got;

    // T=0xFF: unreachable
    run_scan(8'hFF, 1'b0, 1'b0, dc, cn, sb, st, nv, b1);
    chk("tff_no_valid", nv, 0);
    chk("tff_count", cn, 0);
    chk("tff_done_cycle", dc, 258);

    // T=0x04 with random backpressure and a start poke during busy
    run_scan(8'h04, 1'b1, 1'b1, dc, cn, sb, st, nv, b1);
    chk("bp_beats", got.size(), 24);
    diff = 0;
    foreach (got[i]) if (i < ref4.size() && got[i] !== ref4[i]) diff++;
    chk("bp_same_order", diff, 0);
    chk("bp_stable_while_stalled", sb, 0);
    chk("bp_stalls_seen", (st > 0), 1);
    chk("bp_count", cn, 24);
    chk("bp_done_seen", (dc > 0), 1);

    // FIRST_ONLY=1, T=0x04: one beat 0x80
    target = 8'h04; m_ready = 1'b1; start_f = 1'b1;
    @(posedge clk); #1;
    start_f = 1'b0;
    cyc = 1; beats = 0; first = 8'h00; dc = -1; cn = -1;
    while (dc < 0 && cyc < 2000) begin
      @(negedge clk);
      if (m_valid_f && m_ready) begin
        if (beats == 0) first = m_state_f;
        beats++;
      end
      if (done_f) begin dc = cyc; cn = int'(count_f); end
      @(posedge clk); #1;
      cyc++;
    end
    chk("fo_beats", beats, 1);
    chk("fo_first", first, 8'h80);
    chk("fo_count", cn, 1);
    chk("fo_done_cycle", dc, 131);

    // Reset mid-scan with a stalled pending entry, then clean restart
    target = 8'h04; m_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (150) @(posedge clk);
    @(negedge clk);
    chk("mid_pending", m_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_m_state", m_state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    run_scan(8'h00, 1'b0, 1'b0, dc, cn, sb, st, nv, b1);
    chk("restart_count", cn, 2);
    chk("restart_beats", got.size(), 2);
    chk("restart_done_cycle", dc, 258);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
